branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 176 +++++++++++++++++
 tb/tb_branch_predict_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// -----------------------------------------------------------------------------
// branch_predict_unit
//   Direct-mapped branch target buffer with 2-bit saturating counters, plus the
//   resolution logic that computes the actual next PC of a J/BEQ/BNE, detects a
//   mispredict against the PC that was predicted at fetch, and trains the table.
//
// Ports
//   i_BranchPredictUnit_clk           clock, all state changes on rising edge
//   i_BranchPredictUnit_rst           synchronous active-high reset
//   i_BranchPredictUnit_fetchPc       fetch PC to look up (combinational)
//   o_BranchPredictUnit_predPc        predicted next fetch PC
//   o_BranchPredictUnit_predTaken     prediction is taken
//   i_BranchPredictUnit_resValid      resolution request present
//   i_BranchPredictUnit_resPc         PC of the resolving instruction
//   i_BranchPredictUnit_BRop          0010 J, 0100 BEQ, 0001 BNE, else non-branch
//   i_BranchPredictUnit_A/B           compare operands
//   i_BranchPredictUnit_branchOffset  signed word offset
//   i_BranchPredictUnit_jumpTarget    jump target field
//   i_BranchPredictUnit_resPredPc     predPc carried with the instruction
//   o_BranchPredictUnit_mispredict    one-cycle flush pulse
//   o_BranchPredictUnit_redirectPc    correct PC, valid while mispredict is high
//   o_BranchPredictUnit_branchCount   resolved branches (saturating)
//   o_BranchPredictUnit_missCount     mispredicts (saturating)
// -----------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int ENTRIES     = 16,
  parameter bit ENABLE_PRED = 1'b1
) (
  input  logic        i_BranchPredictUnit_clk,
  input  logic        i_BranchPredictUnit_rst,
  input  logic [31:0] i_BranchPredictUnit_fetchPc,
  output logic [31:0] o_BranchPredictUnit_predPc,
  output logic        o_BranchPredictUnit_predTaken,
  input  logic        i_BranchPredictUnit_resValid,
  input  logic [31:0] i_BranchPredictUnit_resPc,
  input  logic [3:0]  i_BranchPredictUnit_BRop,
  input  logic [31:0] i_BranchPredictUnit_A,
  input  logic [31:0] i_BranchPredictUnit_B,
  input  logic [15:0] i_BranchPredictUnit_branchOffset,
  input  logic [15:0] i_BranchPredictUnit_jumpTarget,
  input  logic [31:0] i_BranchPredictUnit_resPredPc,
  output logic        o_BranchPredictUnit_mispredict,
  output logic [31:0] o_BranchPredictUnit_redirectPc,
  output logic [31:0] o_BranchPredictUnit_branchCount,
  output logic [31:0] o_BranchPredictUnit_missCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [3:0] OP_J   = 4'b0010;
  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_BNE = 4'b0001;

  // Table storage
  logic             valid_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q     [ENTRIES];
  logic [31:0]      target_q  [ENTRIES];
  logic             is_jump_q [ENTRIES];
  logic [1:0]       ctr_q     [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup (combinational, sees pre-update contents)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;

  assign f_idx = i_BranchPredictUnit_fetchPc[IDX_W+1:2];
  assign f_tag = i_BranchPredictUnit_fetchPc[31:IDX_W+2];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    o_BranchPredictUnit_predTaken = 1'b0;
    o_BranchPredictUnit_predPc    = i_BranchPredictUnit_fetchPc + 32'd4;
    if (ENABLE_PRED && valid_q[f_idx] && (tag_q[f_idx] == f_tag) &&
        (is_jump_q[f_idx] || ctr_q[f_idx][1])) begin
      o_BranchPredictUnit_predTaken = 1'b1;
      o_BranchPredictUnit_predPc    = target_q[f_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic             is_j, is_beq, is_bne, is_br, cond_taken, taken, mispred;
  logic [31:0]      seq_pc, br_off, actual_pc;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit, do_update;

  assign is_j       = (i_BranchPredictUnit_BRop == OP_J);
  assign is_beq     = (i_BranchPredictUnit_BRop == OP_BEQ);
  assign is_bne     = (i_BranchPredictUnit_BRop == OP_BNE);
  assign is_br      = is_j | is_beq | is_bne;
  assign cond_taken = (is_beq && (i_BranchPredictUnit_A == i_BranchPredictUnit_B)) ||
                      (is_bne && (i_BranchPredictUnit_A != i_BranchPredictUnit_B));
  assign taken      = is_j | cond_taken;

  assign seq_pc = i_BranchPredictUnit_resPc + 32'd4;
  assign br_off = {{14{i_BranchPredictUnit_branchOffset[15]}},
                   i_BranchPredictUnit_branchOffset, 2'b00};

  always_comb begin
    actual_pc = seq_pc;
    if (is_j)
      actual_pc = {seq_pc[31:28], 10'b0, i_BranchPredictUnit_jumpTarget, 2'b00};
    else if (cond_taken)
      actual_pc = seq_pc + br_off;
  end

  assign mispred   = i_BranchPredictUnit_resValid &&
                     (actual_pc != i_BranchPredictUnit_resPredPc);
  assign r_idx     = i_BranchPredictUnit_resPc[IDX_W+1:2];
  assign r_tag     = i_BranchPredictUnit_resPc[31:IDX_W+2];
  assign r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign do_update = i_BranchPredictUnit_resValid && is_br;

  // Valid bits and counters: reset, trained on every resolved branch.
  always_ff @(posedge i_BranchPredictUnit_clk) begin
    if (i_BranchPredictUnit_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: non-blocking for all sequential state so every register
        // samples pre-edge values regardless of statement order.
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (do_update) begin
      if (r_hit) begin
        if (is_j)
          ctr_q[r_idx] <= 2'b11;
        else if (taken && ctr_q[r_idx] != 2'b11)
          ctr_q[r_idx] <= ctr_q[r_idx] + 2'd1;
        else if (!taken && ctr_q[r_idx] != 2'b00)
          ctr_q[r_idx] <= ctr_q[r_idx] - 2'd1;
      end else if (taken) begin
        valid_q[r_idx] <= 1'b1;
        ctr_q[r_idx]   <= is_j ? 2'b11 : 2'b10;
      end
    end
  end

  // Tag/target/isJump payload.
  // NOTE: payload is not reset; it is qualified by valid_q, so clearing it
  // would only add reset fan-out to a RAM-like structure.
  always_ff @(posedge i_BranchPredictUnit_clk) begin
    if (!i_BranchPredictUnit_rst && do_update && taken) begin
      target_q[r_idx] <= actual_pc;
      if (r_hit) begin
        if (is_j) is_jump_q[r_idx] <= 1'b1;
      end else begin
        tag_q[r_idx]     <= r_tag;
        is_jump_q[r_idx] <= is_j;
      end
    end
  end

  // Flush pulse, redirect and performance counters.
  always_ff @(posedge i_BranchPredictUnit_clk) begin
    if (i_BranchPredictUnit_rst) begin
      o_BranchPredictUnit_mispredict  <= 1'b0;
      o_BranchPredictUnit_redirectPc  <= 32'd0;
      o_BranchPredictUnit_branchCount <= 32'd0;
      o_BranchPredictUnit_missCount   <= 32'd0;
    end else begin
      o_BranchPredictUnit_mispredict <= mispred;
      if (mispred) begin
        o_BranchPredictUnit_redirectPc <= actual_pc;
        if (o_BranchPredictUnit_missCount != 32'hFFFF_FFFF)
          o_BranchPredictUnit_missCount <= o_BranchPredictUnit_missCount + 32'd1;
      end
      if (do_update && o_BranchPredictUnit_branchCount != 32'hFFFF_FFFF)
        o_BranchPredictUnit_branchCount <= o_BranchPredictUnit_branchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_unit
//   Directed scenarios with literal expectations followed by randomized
//   resolutions; a behavioural model of the predictor is compared against the
//   DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam int ENTRIES = 16;

  localparam logic [3:0] OP_J   = 4'b0010;
  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_BNE = 4'b0001;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [3:0]  br_op;
  logic [31:0] op_a, op_b;
  logic [15:0] br_offset;
  logic [15:0] jump_target;
  logic [31:0] res_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] miss_count;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  branch_predict_unit #(.ENTRIES(ENTRIES), .ENABLE_PRED(1'b1)) dut (
    .i_BranchPredictUnit_clk         (clk),
    .i_BranchPredictUnit_rst         (rst),
    .i_BranchPredictUnit_fetchPc     (fetch_pc),
    .o_BranchPredictUnit_predPc      (pred_pc),
    .o_BranchPredictUnit_predTaken   (pred_taken),
    .i_BranchPredictUnit_resValid    (res_valid),
    .i_BranchPredictUnit_resPc       (res_pc),
    .i_BranchPredictUnit_BRop        (br_op),
    .i_BranchPredictUnit_A           (op_a),
    .i_BranchPredictUnit_B           (op_b),
    .i_BranchPredictUnit_branchOffset(br_offset),
    .i_BranchPredictUnit_jumpTarget  (jump_target),
    .i_BranchPredictUnit_resPredPc   (res_pred_pc),
    .o_BranchPredictUnit_mispredict  (mispredict),
    .o_BranchPredictUnit_redirectPc  (redirect_pc),
    .o_BranchPredictUnit_branchCount (branch_count),
    .o_BranchPredictUnit_missCount   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: each slot remembers the full word address of its owner.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit [29:0]   owner;
    bit [31:0]   target;
    bit          is_jump;
    int          ctr;
  } entry_t;

  entry_t      m_tab [ENTRIES];
  bit          m_mis;
  bit [31:0]   m_redir;
  longint      m_bc, m_mc;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [32:0] m_lookup(input logic [31:0] pc);
    int s = slot_of(pc);
    if (m_tab[s].valid && m_tab[s].owner == pc[31:2] &&
        (m_tab[s].is_jump || m_tab[s].ctr >= 2))
      return {1'b1, m_tab[s].target};
    return {1'b0, pc + 32'd4};
  endfunction

  function automatic logic [32:0] m_actual(input logic [3:0] op, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [15:0] off, input logic [15:0] jt);
    logic [31:0] seq = pc + 32'd4;
    logic [31:0] soff = 32'(signed'(off)) * 32'd4;
    if (op == OP_J)
      return {1'b1, (seq & 32'hF000_0000) | (32'(jt) << 2)};
    if ((op == OP_BEQ && a == b) || (op == OP_BNE && a != b))
      return {1'b1, seq + soff};
    return {1'b0, seq};
  endfunction

  always @(posedge clk) begin : model_update
    logic [32:0] act;
    int          s;
    bit          is_br;
    if (rst) begin
      foreach (m_tab[i]) begin
        m_tab[i].valid = 1'b0;
        m_tab[i].ctr   = 1;
      end
      m_mis = 1'b0; m_redir = '0; m_bc = 0; m_mc = 0;
    end else begin
      m_mis = 1'b0;
      if (res_valid) begin
        act   = m_actual(br_op, res_pc, op_a, op_b, br_offset, jump_target);
        is_br = (br_op == OP_J) || (br_op == OP_BEQ) || (br_op == OP_BNE);
        if (is_br) begin
          m_bc = (m_bc < 64'hFFFF_FFFF) ? m_bc + 1 : m_bc;
          s = slot_of(res_pc);
          if (m_tab[s].valid && m_tab[s].owner == res_pc[31:2]) begin
            if (br_op == OP_J) begin
              m_tab[s].ctr = 3; m_tab[s].is_jump = 1'b1;
            end else begin
              m_tab[s].ctr = act[32] ? ((m_tab[s].ctr < 3) ? m_tab[s].ctr + 1 : 3)
                                     : ((m_tab[s].ctr > 0) ? m_tab[s].ctr - 1 : 0);
            end
            if (act[32]) m_tab[s].target = act[31:0];
          end else if (act[32]) begin
            m_tab[s].valid   = 1'b1;
            m_tab[s].owner   = res_pc[31:2];
            m_tab[s].target  = act[31:0];
            m_tab[s].is_jump = (br_op == OP_J);
            m_tab[s].ctr     = (br_op == OP_J) ? 3 : 2;
          end
        end
        if (act[31:0] != res_pred_pc) begin
          m_mis   = 1'b1;
          m_redir = act[31:0];
          m_mc    = (m_mc < 64'hFFFF_FFFF) ? m_mc + 1 : m_mc;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [32:0] p;
    if (check_en) begin
      p = m_lookup(fetch_pc);
      check("model_pred_taken", {31'd0, pred_taken}, {31'd0, p[32]});
      check("model_pred_pc",    pred_pc,             p[31:0]);
      check("model_mispredict", {31'd0, mispredict}, {31'd0, m_mis});
      check("model_redirect",   redirect_pc,         m_redir);
      check("model_branch_cnt", branch_count,        32'(m_bc));
      check("model_miss_cnt",   miss_count,          32'(m_mc));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [3:0] op, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] off, input logic [15:0] jt,
                         input logic [31:0] pp);
    res_valid = 1'b1; br_op = op; res_pc = pc; op_a = a; op_b = b;
    br_offset = off; jump_target = jt; res_pred_pc = pp;
  endtask

  function automatic logic [31:0] gen_pc();
    logic [31:0] pc = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | (32'($urandom_range(1, 15)) << 28);
    return pc;
  endfunction

  logic [3:0] op_pool [6] = '{OP_J, OP_BEQ, OP_BNE, 4'b0000, 4'b1000, 4'b1111};

  initial begin
    logic [32:0] tmp;
    rst = 1'b1; fetch_pc = '0;
    resolve(4'b0000, 32'd0, 32'd0, 32'd0, 16'd0, 16'd0, 32'd0);
    res_valid = 1'b0;
    tick();
    check_en = 1'b1;
    rst      = 1'b0;

    // Reset state and wrap-around of the sequential prediction.
    fetch_pc = 32'h100;
    @(negedge clk);
    check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("rst_pred_pc",    pred_pc,             32'h104);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_branch_cnt", branch_count,        32'd0);
    check("rst_miss_cnt",   miss_count,          32'd0);
    tick();
    fetch_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check("wrap_pred_pc", pred_pc, 32'h0);
    tick();

    // Taken BEQ allocates; same-cycle lookup still misses.
    resolve(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 16'h0, 32'h104);
    fetch_pc = 32'h100;
    @(negedge clk);
    check("beq_same_cycle_pc", pred_pc, 32'h104);
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("beq_mispredict", {31'd0, mispredict}, 32'd1);
    check("beq_redirect",   redirect_pc,         32'h114);
    check("beq_miss_cnt",   miss_count,          32'd1);
    check("beq_branch_cnt", branch_count,        32'd1);
    check("beq_pred_pc",    pred_pc,             32'h114);
    check("beq_pred_taken", {31'd0, pred_taken}, 32'd1);
    tick();

    // Two not-taken resolutions: 10 -> 01 (mispredict) -> 00 (no mispredict).
    resolve(OP_BEQ, 32'h100, 32'd1, 32'd2, 16'h0004, 16'h0, 32'h114);
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("nt1_mispredict", {31'd0, mispredict}, 32'd1);
    check("nt1_redirect",   redirect_pc,         32'h104);
    check("nt1_pred_pc",    pred_pc,             32'h104);
    tick();
    resolve(OP_BEQ, 32'h100, 32'd1, 32'd2, 16'h0004, 16'h0, 32'h104);
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("nt2_mispredict", {31'd0, mispredict}, 32'd0);
    check("nt2_redirect",   redirect_pc,         32'h104);
    check("nt2_pred_pc",    pred_pc,             32'h104);
    check("nt2_branch_cnt", branch_count,        32'd3);
    tick();

    // Jump allocation.
    resolve(OP_J, 32'h200, 32'd0, 32'd0, 16'h0, 16'h0040, 32'h204);
    tick();
    res_valid = 1'b0;
    fetch_pc  = 32'h200;
    @(negedge clk);
    check("j_redirect",   redirect_pc,         32'h100);
    check("j_pred_pc",    pred_pc,             32'h100);
    check("j_pred_taken", {31'd0, pred_taken}, 32'd1);
    check("j_miss_cnt",   miss_count,          32'd3);
    tick();

    // Index conflict: 0x140 evicts 0x100.
    resolve(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 16'h0, 32'h104);
    tick();
    resolve(OP_BEQ, 32'h140, 32'd5, 32'd5, 16'h0004, 16'h0, 32'h144);
    fetch_pc = 32'h140;
    @(negedge clk);
    check("conflict_same_cycle", pred_pc, 32'h144);
    tick();
    res_valid = 1'b0;
    fetch_pc  = 32'h100;
    @(negedge clk);
    check("conflict_evicted_pc", pred_pc,     32'h104);
    check("conflict_redirect",   redirect_pc, 32'h154);
    tick();
    fetch_pc = 32'h140;
    @(negedge clk);
    check("conflict_new_pc", pred_pc, 32'h154);
    tick();

    // Non-branch op: may mispredict but does not count as a branch.
    resolve(4'b0000, 32'h300, 32'd0, 32'd0, 16'h0, 16'h0, 32'h400);
    tick();
    res_valid = 1'b0;
    @(negedge clk);
    check("nonbr_mispredict", {31'd0, mispredict}, 32'd1);
    check("nonbr_redirect",   redirect_pc,         32'h304);
    check("nonbr_branch_cnt", branch_count,        32'd6);
    check("nonbr_miss_cnt",   miss_count,          32'd6);
    tick();

    // Reset wins over a concurrent mispredicting resolution.
    rst = 1'b1;
    resolve(OP_BEQ, 32'h140, 32'd5, 32'd5, 16'h0004, 16'h0, 32'h0);
    tick();
    rst       = 1'b0;
    res_valid = 1'b0;
    fetch_pc  = 32'h140;
    @(negedge clk);
    check("rstpri_mispredict", {31'd0, mispredict}, 32'd0);
    check("rstpri_branch_cnt", branch_count,        32'd0);
    check("rstpri_miss_cnt",   miss_count,          32'd0);
    check("rstpri_pred_pc",    pred_pc,             32'h144);
    tick();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      resolve(op_pool[$urandom_range(0, 5)], gen_pc(), $urandom, $urandom,
              16'($urandom), 16'($urandom), 32'd0);
      if ($urandom_range(0, 1) == 0) op_b = op_a;
      if ($urandom_range(0, 1) == 0) br_offset = 16'($signed($urandom_range(0, 15)) - 8);
      res_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin tmp = m_lookup(res_pc); res_pred_pc = tmp[31:0]; end
        1: res_pred_pc = res_pc + 32'd4;
        2: begin
             tmp = m_actual(br_op, res_pc, op_a, op_b, br_offset, jump_target);
             res_pred_pc = tmp[31:0];
           end
        default: res_pred_pc = $urandom;
      endcase
      fetch_pc = ($urandom_range(0, 1) == 0) ? res_pc : gen_pc();
      tick();
    end

    rst = 1'b0; res_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
